// File: rtl/dm_access.sv
// dm_access: data-memory responder for the MIPS core.
// Serves one load or store at a time over valid/ready request/response
// handshakes. Sub-word stores read-modify-write a word-wide single-port
// synchronous RAM that has no byte enables. Loads are sign/zero extended.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_we, req_ld               store code / load code (load code used when req_we==00)
//   req_addr, req_wdata          byte address, store data
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata, rsp_err           extended load data, request-rejected flag
module dm_access #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_we,
  input  logic [2:0]  req_ld,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_SW   = 2'b01;
  localparam logic [1:0] WE_SB   = 2'b10;
  localparam logic [1:0] WE_SH   = 2'b11;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WB   = 2'd2,
    S_RSP  = 2'd3
  } state_e;

  state_e              state_q;
  logic [1:0]          we_q;
  logic [2:0]          ld_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                err_q;
  logic [31:0]         ram_q;
  logic [31:0]         mem [DEPTH];

  logic                acc_err_c;
  logic [ADDR_W-1:0]   idx_c;
  logic [31:0]         wr_word_c;
  logic [7:0]          byte_c;
  logic [15:0]         half_c;
  logic [31:0]         ld_word_c;
  logic                unused_addr;

  // Address bits above the word index are ignored, so addresses wrap.
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign idx_c       = addr_q[ADDR_W+1:2];

  // Alignment and load-code checks on the live request.
  always_comb begin
    acc_err_c = 1'b0;
    case (req_we)
      WE_SW:   acc_err_c = (req_addr[1:0] != 2'b00);
      WE_SH:   acc_err_c = req_addr[0];
      WE_SB:   acc_err_c = 1'b0;
      default: begin
        case (req_ld)
          LD_LW:          acc_err_c = (req_addr[1:0] != 2'b00);
          LD_LB, LD_LBU:  acc_err_c = 1'b0;
          LD_LH, LD_LHU:  acc_err_c = req_addr[0];
          default:        acc_err_c = 1'b1;
        endcase
      end
    endcase
  end

  // Control FSM and request latch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      we_q    <= WE_NONE;
      ld_q    <= LD_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            ld_q    <= req_ld;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
            err_q   <= acc_err_c;
            if (acc_err_c)            state_q <= S_RSP;
            else if (req_we == WE_SW) state_q <= S_WB;
            else                      state_q <= S_RD;
          end
        end
        S_RD:    state_q <= ((we_q == WE_SB) || (we_q == WE_SH)) ? S_WB : S_RSP;
        S_WB:    state_q <= S_RSP;
        S_RSP:   if (rsp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Single-port RAM; contents are not reset and a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (state_q == S_RD) ram_q <= mem[idx_c];
    if (rstn && (state_q == S_WB)) mem[idx_c] <= wr_word_c;
  end

  // Merge sub-word store data into the word captured in RD.
  always_comb begin
    wr_word_c = wdata_q;
    if (we_q == WE_SB) begin
      wr_word_c = ram_q;
      case (addr_q[1:0])
        2'd0:    wr_word_c[7:0]   = wdata_q[7:0];
        2'd1:    wr_word_c[15:8]  = wdata_q[7:0];
        2'd2:    wr_word_c[23:16] = wdata_q[7:0];
        default: wr_word_c[31:24] = wdata_q[7:0];
      endcase
    end else if (we_q == WE_SH) begin
      wr_word_c = ram_q;
      if (addr_q[1]) wr_word_c[31:16] = wdata_q[15:0];
      else           wr_word_c[15:0]  = wdata_q[15:0];
    end
  end

  // Lane select and extension of load data.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_c = ram_q[7:0];
      2'd1:    byte_c = ram_q[15:8];
      2'd2:    byte_c = ram_q[23:16];
      default: byte_c = ram_q[31:24];
    endcase
    half_c = addr_q[1] ? ram_q[31:16] : ram_q[15:0];
    case (ld_q)
      LD_LW:   ld_word_c = ram_q;
      LD_LB:   ld_word_c = {{24{byte_c[7]}}, byte_c};
      LD_LBU:  ld_word_c = {24'd0, byte_c};
      LD_LH:   ld_word_c = {{16{half_c[15]}}, half_c};
      LD_LHU:  ld_word_c = {16'd0, half_c};
      default: ld_word_c = 32'd0;
    endcase
  end

  // Response fields are decoded from held registers, so they stay stable in RSP.
  assign req_ready = rstn && (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_err   = (state_q == S_RSP) && err_q;
  assign rsp_rdata = ((state_q == S_RSP) && !err_q && (we_q == WE_NONE)) ? ld_word_c : 32'd0;

endmodule

// File: tb/tb_dm_access.sv
// Directed bench for dm_access: stores, loads, extension, errors,
// backpressure, mid-transaction reset and address wrap.
module tb_dm_access;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_we;
  logic [2:0]  req_ld;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_access #(.ADDR_W(10)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_ld    (req_ld),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called at accept-edge+1; returns cycles until rsp_valid (bounded).
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  // One full transaction with rsp_ready high; ends at handshake-edge+1.
  task automatic run_req(input string tag, input logic [1:0] we, input logic [2:0] ld,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_ld = ld; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 2'(3); req_ld = 3'(7);
    req_addr = 32'hFFFF_FFFF; req_wdata = $urandom;
    wait_rsp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int lat;
    rstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_we = 2'b00; req_ld = 3'b000; req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rstn = 1'b1; #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Word and sub-word stores, loads with extension
    run_req("sw10",  2'b01, 3'd0, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 2);
    run_req("lw10a", 2'b00, 3'd0, 32'h10, 32'h0,        32'h1234_5678, 1'b0, 2);
    run_req("sb11",  2'b10, 3'd0, 32'h11, 32'h5566_77AA, 32'h0, 1'b0, 3);
    run_req("lw10b", 2'b00, 3'd0, 32'h10, 32'h0,        32'h1234_AA78, 1'b0, 2);
    run_req("sh12",  2'b11, 3'd0, 32'h12, 32'h9999_BEEF, 32'h0, 1'b0, 3);
    run_req("lw10c", 2'b00, 3'd0, 32'h10, 32'h0,        32'hBEEF_AA78, 1'b0, 2);
    run_req("lh12",  2'b00, 3'd3, 32'h12, 32'h0,        32'hFFFF_BEEF, 1'b0, 2);
    run_req("lhu12", 2'b00, 3'd4, 32'h12, 32'h0,        32'h0000_BEEF, 1'b0, 2);
    run_req("lb11",  2'b00, 3'd1, 32'h11, 32'h0,        32'hFFFF_FFAA, 1'b0, 2);
    run_req("lbu11", 2'b00, 3'd2, 32'h11, 32'h0,        32'h0000_00AA, 1'b0, 2);
    run_req("lb10",  2'b00, 3'd1, 32'h10, 32'h0,        32'h0000_0078, 1'b0, 2);
    run_req("lh10",  2'b00, 3'd3, 32'h10, 32'h0,        32'hFFFF_AA78, 1'b0, 2);

    // Misaligned and illegal requests
    run_req("sw13",  2'b01, 3'd0, 32'h13, 32'hDEAD_BEEF, 32'h0, 1'b1, 1);
    run_req("lw10d", 2'b00, 3'd0, 32'h10, 32'h0,        32'hBEEF_AA78, 1'b0, 2);
    run_req("lh11",  2'b00, 3'd3, 32'h11, 32'h0,        32'h0, 1'b1, 1);
    run_req("ld110", 2'b00, 3'd6, 32'h10, 32'h0,        32'h0, 1'b1, 1);
    run_req("sh11",  2'b11, 3'd0, 32'h11, 32'h0000_1111, 32'h0, 1'b1, 1);
    run_req("lw12",  2'b00, 3'd0, 32'h12, 32'h0,        32'h0, 1'b1, 1);
    run_req("lw10e", 2'b00, 3'd0, 32'h10, 32'h0,        32'hBEEF_AA78, 1'b0, 2);

    // Backpressure; a second request held pending must wait, then be taken
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 2'b00; req_ld = 3'd0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_ld = 3'd2; req_addr = 32'h13;
    wait_rsp(lat);
    chk("bp_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hBEEF_AA78);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_back_idle", 32'(req_ready), 32'd1);
    chk("bp_valid_low", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pend_busy", 32'(req_ready), 32'd0);
    wait_rsp(lat);
    chk("pend_lat", 32'(lat), 32'd2);
    chk("pend_rdata", rsp_rdata, 32'h0000_00BE);
    @(posedge clk); #1;

    // Reset during the WB cycle of sb suppresses the write
    req_valid = 1'b1; req_we = 2'b10; req_ld = 3'd0; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("wbrst_valid", 32'(rsp_valid), 32'd0);
    chk("wbrst_ready_low", 32'(req_ready), 32'd0);
    rstn = 1'b1; #1;
    chk("wbrst_ready_rel", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("wbrst_no_rsp", 32'(rsp_valid), 32'd0);
    run_req("lw10f", 2'b00, 3'd0, 32'h10, 32'h0, 32'hBEEF_AA78, 1'b0, 2);

    // Address wrap
    run_req("sw1000", 2'b01, 3'd0, 32'h1000, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
    run_req("lw0",    2'b00, 3'd0, 32'h0,    32'h0, 32'hCAFE_F00D, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_access.md
# dm_access

Data-memory responder for the MIPS core. It serves one load or store at a time, as encoded by the core's control unit (MemWrite store code, LAddr load code), over a valid/ready request and response handshake. Sub-word stores use read-modify-write on an internal single-port, word-wide synchronous RAM that has no byte enables. Load results are sign- or zero-extended before return.

## Interface
- ADDR_W, 10, word-address bits; RAM holds 2^ADDR_W 32-bit words.
- clk  in  1  rising-edge clock.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  2  store code: 00 none (load), 01 sw, 10 sb, 11 sh.
- req_ld  in  3  load code, used only when req_we==00: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sb uses [7:0], sh uses [15:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; memory is unchanged.

## Operation
- Byte order is little-endian: byte k of a word is bits [8k+7:8k]. Word index is req_addr[ADDR_W+1:2]. Address bits above that index are ignored, so addresses wrap.
- Request is accepted on a rising edge with req_valid & req_ready. The block latches req_we, req_ld, req_addr and req_wdata at that edge. Later changes to the request inputs have no effect.
- If req_we != 00, the request is a store and req_ld is ignored.
- Error checks at acceptance:
  - sw/lw need addr[1:0]==00.
  - sh/lh/lhu need addr[0]==0.
  - sb/lb/lbu have no alignment requirement.
  - A load code of 101–111 is an error.
- FSM states: IDLE, RD, WB, RSP.
  - IDLE: req_ready=1. On acceptance:
    - error → RSP
    - sw → WB
    - any load, sb or sh → RD
  - RD: RAM read of the latched word. Data is captured at the end of the cycle. Next state is WB for sb/sh, otherwise RSP.
  - WB: one-cycle RAM write.
    - sw writes the full word.
    - sb replaces byte addr[1:0] of the captured word with wdata[7:0].
    - sh replaces halfword addr[1] with wdata[15:0].
    - Next state is RSP.
  - RSP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready, then the FSM returns to IDLE.
- Load extension:
  - lb: sign-extends the selected byte.
  - lbu: zero-extends the selected byte.
  - lh: sign-extends the selected halfword.
  - lhu: zero-extends the selected halfword.
  - lw: returns the word unchanged.
- An error response has rsp_err=1 and rsp_rdata=0. Success has rsp_err=0.
- Only one transaction is outstanding. req_ready=0 in every state except IDLE.

## Timing
- Reset (rstn=0 at an edge): the FSM goes to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready is 0 while rstn=0 and 1 on the first cycle after release.
- RAM contents are not reset.
- Reset mid-transaction aborts it. A WB-cycle write coincident with rstn=0 is suppressed. No response is produced.
- Latency, counted from the accepting edge to the first cycle with rsp_valid=1:
  - error: 1 cycle
  - lw/lb/lbu/lh/lhu: 2 cycles
  - sw: 2 cycles
  - sb/sh: 3 cycles
- The RAM write becomes visible to the RD cycle of any later request.
- Back-to-back throughput: the RSP→IDLE transition takes one edge. A new request can be accepted on the edge after the response handshake at the earliest.
- rsp_ready held low: the block stays in RSP indefinitely with outputs stable and accepts no requests.
- req_valid held high while the block is busy: the request is ignored until IDLE and is then accepted on the first IDLE edge.

## Test plan
- sw 0x12345678 to 0x10, then lw 0x10 → rsp_rdata=0x12345678, err=0. Measured latencies are 2 and 2.
- After that word is stored: sb 0xAA to 0x11, then lw 0x10 → 0x1234AA78. sb latency is 3.
- After that word is stored: sh 0xBEEF to 0x12, then lw 0x10 → 0xBEEFAA78. Then:
  - lh 0x12 → 0xFFFFBEEF
  - lhu 0x12 → 0x0000BEEF
  - lb 0x11 → 0xFFFFFFAA
  - lbu 0x11 → 0x000000AA
- Misaligned and illegal requests:
  - sw to 0x13 → err=1, rdata=0 after 1 cycle.
  - A following lw 0x10 shows the word unchanged.
  - lh at 0x11 → err.
  - Load code 110 → err.
- Backpressure and reset:
  - lw response with rsp_ready=0 for 5 cycles → rsp_valid and rdata stable, req_ready=0 throughout.
  - Assert rstn=0 during the WB cycle of sb 0x55 to 0x10 → the word at 0x10 is unchanged afterwards, rsp_valid=0, and req_ready=1 the cycle after release.
- Address wrap (ADDR_W=10): sw 0xCAFEF00D to 0x1000, then lw 0x0 → 0xCAFEF00D.
